// File: rtl/vx_dot8_commit_gather_if.sv
// Commit packet bus into the dot8 gather block: one partial-lane packet per beat.
interface vx_dot8_commit_gather_if #(
    parameter int unsigned NUM_LANES  = 1,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned UUID_WIDTH = 44,
    parameter int unsigned NW_WIDTH   = 2,
    parameter int unsigned PC_BITS    = 30,
    parameter int unsigned NR_BITS    = 5,
    parameter int unsigned PID_WIDTH  = 1
);
    logic                                valid;
    logic                                ready;
    logic [UUID_WIDTH-1:0]               uuid;
    logic [NW_WIDTH-1:0]                 wid;
    logic [NUM_LANES-1:0]                tmask;
    logic [PC_BITS-1:0]                  PC;
    logic [NR_BITS-1:0]                  rd;
    logic                                wb;
    logic [PID_WIDTH-1:0]                pid;
    logic                                sop;
    logic                                eop;
    logic [NUM_LANES-1:0][XLEN-1:0]      data;

    modport master (
        output valid, uuid, wid, tmask, PC, rd, wb, pid, sop, eop, data,
        input  ready
    );

    modport slave (
        input  valid, uuid, wid, tmask, PC, rd, wb, pid, sop, eop, data,
        output ready
    );
endinterface

// File: rtl/vx_dot8_commit_gather.sv
// Gathers partial-lane dot8 commit packets (sop..eop, indexed by pid) into one
// full-warp writeback. Optional macro DOT8_GATHER_SKID_EN adds a second result
// buffer so a new gather can proceed while the previous result is still held.
// NUM_THREADS must be a multiple of NUM_LANES.
module vx_dot8_commit_gather #(
    parameter string       INSTANCE_ID = "",
    parameter int unsigned NUM_LANES   = 1,
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned UUID_WIDTH  = 44,
    parameter int unsigned NW_WIDTH    = 2,
    parameter int unsigned PC_BITS     = 30,
    parameter int unsigned NR_BITS     = 5
) (
    input  logic                                  clk,
    input  logic                                  reset,
    vx_dot8_commit_gather_if.slave                commit_in_if,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [UUID_WIDTH-1:0]                 out_uuid,
    output logic [NW_WIDTH-1:0]                   out_wid,
    output logic [PC_BITS-1:0]                    out_PC,
    output logic [NR_BITS-1:0]                    out_rd,
    output logic                                  out_wb,
    output logic [NUM_THREADS-1:0]                out_tmask,
    output logic [NUM_THREADS-1:0][XLEN-1:0]      out_data,
    output logic                                  busy
);

    localparam int unsigned PID_COUNT = NUM_THREADS / NUM_LANES;
    localparam int unsigned PID_WIDTH = (PID_COUNT > 1) ? $clog2(PID_COUNT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATHER = 2'd1,
        HOLD   = 2'd2
    } state_e;

    state_e                              state_q, state_d;
    logic                                ready_q, ready_d;
    logic                                out_valid_q, out_valid_d;
    logic                                busy_q, busy_d;

    // Gather buffer
    logic [UUID_WIDTH-1:0]               g_uuid_q, g_uuid_d;
    logic [NW_WIDTH-1:0]                 g_wid_q, g_wid_d;
    logic [PC_BITS-1:0]                  g_pc_q, g_pc_d;
    logic [NR_BITS-1:0]                  g_rd_q, g_rd_d;
    logic                                g_wb_q, g_wb_d;
    logic [NUM_THREADS-1:0]              g_tmask_q, g_tmask_d;
    logic [NUM_THREADS-1:0][XLEN-1:0]    g_data_q, g_data_d;
    logic [PID_WIDTH-1:0]                last_pid_q, last_pid_d;

    // Gather buffer with the current packet merged in
    logic [UUID_WIDTH-1:0]               m_uuid_c;
    logic [NW_WIDTH-1:0]                 m_wid_c;
    logic [PC_BITS-1:0]                  m_pc_c;
    logic [NR_BITS-1:0]                  m_rd_c;
    logic                                m_wb_c;
    logic [NUM_THREADS-1:0]              m_tmask_c;
    logic [NUM_THREADS-1:0][XLEN-1:0]    m_data_c;

    logic                                in_sop_c, in_eop_c, accept_c, g_load_c;
    logic [PID_WIDTH-1:0]                in_pid_c;

`ifdef DOT8_GATHER_SKID_EN
    // Result buffer feeding the output port
    logic [UUID_WIDTH-1:0]               r_uuid_q, r_uuid_d;
    logic [NW_WIDTH-1:0]                 r_wid_q, r_wid_d;
    logic [PC_BITS-1:0]                  r_pc_q, r_pc_d;
    logic [NR_BITS-1:0]                  r_rd_q, r_rd_d;
    logic                                r_wb_q, r_wb_d;
    logic [NUM_THREADS-1:0]              r_tmask_q, r_tmask_d;
    logic [NUM_THREADS-1:0][XLEN-1:0]    r_data_q, r_data_d;
    logic                                r_load_c, r_from_g_c, r_free_c, r_full_d;
`endif

    // With a single pid batch every packet is a complete warp
    assign in_sop_c = (PID_COUNT == 1) ? 1'b1 : commit_in_if.sop;
    assign in_eop_c = (PID_COUNT == 1) ? 1'b1 : commit_in_if.eop;
    assign in_pid_c = (PID_COUNT == 1) ? '0 : commit_in_if.pid;
    assign accept_c = commit_in_if.valid && ready_q;

    assign commit_in_if.ready = ready_q;
    assign out_valid          = out_valid_q;
    assign busy               = busy_q;

`ifdef DOT8_GATHER_SKID_EN
    assign r_free_c  = !out_valid_q || out_ready;
    assign out_uuid  = r_uuid_q;
    assign out_wid   = r_wid_q;
    assign out_PC    = r_pc_q;
    assign out_rd    = r_rd_q;
    assign out_wb    = r_wb_q;
    assign out_tmask = r_tmask_q;
    assign out_data  = r_data_q;
`else
    assign out_uuid  = g_uuid_q;
    assign out_wid   = g_wid_q;
    assign out_PC    = g_pc_q;
    assign out_rd    = g_rd_q;
    assign out_wb    = g_wb_q;
    assign out_tmask = g_tmask_q;
    assign out_data  = g_data_q;
`endif

    // Merge the incoming packet's lanes into slots pid*NUM_LANES+i
    always_comb begin
        m_uuid_c  = g_uuid_q;
        m_wid_c   = g_wid_q;
        m_pc_c    = g_pc_q;
        m_rd_c    = g_rd_q;
        m_wb_c    = g_wb_q;
        m_tmask_c = g_tmask_q;
        m_data_c  = g_data_q;
        if (in_sop_c) begin
            m_uuid_c  = commit_in_if.uuid;
            m_wid_c   = commit_in_if.wid;
            m_pc_c    = commit_in_if.PC;
            m_rd_c    = commit_in_if.rd;
            m_wb_c    = commit_in_if.wb;
            m_tmask_c = '0;
            m_data_c  = '0;
        end
        for (int p = 0; p < int'(PID_COUNT); p++) begin
            if (in_pid_c == PID_WIDTH'(p)) begin
                for (int i = 0; i < int'(NUM_LANES); i++) begin
                    m_tmask_c[p * int'(NUM_LANES) + i] = commit_in_if.tmask[i];
                    m_data_c[p * int'(NUM_LANES) + i]  = commit_in_if.data[i];
                end
            end
        end
    end

    // Next-state and buffer-load control
    always_comb begin
        state_d  = state_q;
        g_load_c = 1'b0;
`ifdef DOT8_GATHER_SKID_EN
        r_load_c   = 1'b0;
        r_from_g_c = 1'b0;
`endif
        case (state_q)
            // A non-sop packet while idle has no gather to join and is dropped
            IDLE, GATHER: begin
                if (accept_c && (state_q == GATHER || in_sop_c)) begin
                    g_load_c = 1'b1;
                    state_d  = GATHER;
                    if (in_eop_c) begin
`ifdef DOT8_GATHER_SKID_EN
                        if (r_free_c) begin
                            r_load_c = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            state_d  = HOLD;
                        end
`else
                        state_d = HOLD;
`endif
                    end
                end
            end
            HOLD: begin
`ifdef DOT8_GATHER_SKID_EN
                if (r_free_c) begin
                    r_from_g_c = 1'b1;
                    state_d    = IDLE;
                end
`else
                if (out_ready) begin
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

`ifdef DOT8_GATHER_SKID_EN
        r_full_d    = (out_valid_q && !out_ready) || r_load_c || r_from_g_c;
        out_valid_d = r_full_d;
        busy_d      = (state_d != IDLE) || r_full_d;
`else
        out_valid_d = (state_d == HOLD);
        busy_d      = (state_d != IDLE);
`endif
        ready_d = (state_d != HOLD);
    end

    // Next values of the gather and result buffers
    always_comb begin
        g_uuid_d   = g_load_c ? m_uuid_c  : g_uuid_q;
        g_wid_d    = g_load_c ? m_wid_c   : g_wid_q;
        g_pc_d     = g_load_c ? m_pc_c    : g_pc_q;
        g_rd_d     = g_load_c ? m_rd_c    : g_rd_q;
        g_wb_d     = g_load_c ? m_wb_c    : g_wb_q;
        g_tmask_d  = g_load_c ? m_tmask_c : g_tmask_q;
        g_data_d   = g_load_c ? m_data_c  : g_data_q;
        last_pid_d = accept_c ? in_pid_c  : last_pid_q;
`ifdef DOT8_GATHER_SKID_EN
        r_uuid_d  = r_uuid_q;
        r_wid_d   = r_wid_q;
        r_pc_d    = r_pc_q;
        r_rd_d    = r_rd_q;
        r_wb_d    = r_wb_q;
        r_tmask_d = r_tmask_q;
        r_data_d  = r_data_q;
        if (r_load_c) begin
            r_uuid_d  = m_uuid_c;
            r_wid_d   = m_wid_c;
            r_pc_d    = m_pc_c;
            r_rd_d    = m_rd_c;
            r_wb_d    = m_wb_c;
            r_tmask_d = m_tmask_c;
            r_data_d  = m_data_c;
        end else if (r_from_g_c) begin
            r_uuid_d  = g_uuid_q;
            r_wid_d   = g_wid_q;
            r_pc_d    = g_pc_q;
            r_rd_d    = g_rd_q;
            r_wb_d    = g_wb_q;
            r_tmask_d = g_tmask_q;
            r_data_d  = g_data_q;
        end
`endif
    end

    // Control state and per-thread buffers, cleared on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            g_tmask_q   <= '0;
            g_data_q    <= '0;
            last_pid_q  <= '0;
`ifdef DOT8_GATHER_SKID_EN
            r_tmask_q   <= '0;
            r_data_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            g_tmask_q   <= g_tmask_d;
            g_data_q    <= g_data_d;
            last_pid_q  <= last_pid_d;
`ifdef DOT8_GATHER_SKID_EN
            r_tmask_q   <= r_tmask_d;
            r_data_q    <= r_data_d;
`endif
        end
    end

    // Header payload registers, only meaningful while a result is valid
    always_ff @(posedge clk) begin
        g_uuid_q <= g_uuid_d;
        g_wid_q  <= g_wid_d;
        g_pc_q   <= g_pc_d;
        g_rd_q   <= g_rd_d;
        g_wb_q   <= g_wb_d;
`ifdef DOT8_GATHER_SKID_EN
        r_uuid_q <= r_uuid_d;
        r_wid_q  <= r_wid_d;
        r_pc_q   <= r_pc_d;
        r_rd_q   <= r_rd_d;
        r_wb_q   <= r_wb_d;
`endif
    end

`ifndef SYNTHESIS
    // Upstream packet-order protocol checks
    always_ff @(posedge clk) begin
        if (!reset && accept_c && (PID_COUNT > 1)) begin
            assert (!(state_q == GATHER && commit_in_if.sop))
                else $error("%s: sop inside an open gather, restarting", INSTANCE_ID);
            assert (!(state_q == IDLE && !commit_in_if.sop))
                else $error("%s: packet without sop while idle", INSTANCE_ID);
            assert (!(state_q == GATHER && !commit_in_if.sop && in_pid_c <= last_pid_q))
                else $error("%s: non-increasing pid within a gather", INSTANCE_ID);
        end
    end
`endif

endmodule

// File: doc/vx_dot8_commit_gather.md
VX_DOT8_COMMIT_GATHER -- requirements
Module: VX_dot8_commit_gather

Interface
REQ-001 SHALL have parameter INSTANCE_ID, default "", instance name used only in debug traces.
REQ-002 SHALL have parameter NUM_LANES, default 1, lanes per input packet; `NUM_THREADS % NUM_LANES == 0.
REQ-003 SHALL derive PID_COUNT = `NUM_THREADS/NUM_LANES and PID_WIDTH = `UP(`CLOG2(PID_COUNT)).
REQ-004 SHALL have clk, input, 1: the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have commit_in_if, VX_commit_if.slave, NUM_LANES wide: dot8 results as partial-lane packets carrying uuid, wid, tmask, PC, rd, wb, pid, sop, eop and data.
REQ-007 SHALL have out_valid, output, 1: the gathered full-warp writeback is valid.
REQ-008 SHALL have out_ready, input, 1: the writeback consumer accepts the output.
REQ-009 SHALL have the following outputs: out_uuid (`UUID_WIDTH), out_wid (`NW_WIDTH), out_PC (`PC_BITS), out_rd (`NR_BITS), out_wb (1), out_tmask (`NUM_THREADS) and out_data (`NUM_THREADS x `XLEN).
REQ-010 SHALL have busy, output, 1: a gather is in progress or the output is held.

Function
REQ-011 SHALL implement the states IDLE, GATHER and HOLD.
REQ-012 Input accept SHALL be defined as commit_in_if.valid && commit_in_if.ready; commit_in_if.ready = (state != HOLD), subject to REQ-024.
REQ-013 On an accept with sop=1, the block SHALL latch uuid, wid, PC, rd and wb, and clear the gather tmask and data to 0 before merging the packet.
REQ-014 On any accept, the block SHALL write lane i of the packet into thread slot pid*NUM_LANES+i: tmask bit and data.
REQ-015 Slots whose packets never arrive (pid batches skipped upstream) SHALL read tmask=0 and data=0.
REQ-016 State transitions SHALL be: IDLE -> GATHER on sop&!eop; IDLE or GATHER -> HOLD on eop; HOLD -> IDLE on out_valid&&out_ready.
REQ-017 out_valid SHALL be 1 exactly in HOLD.
REQ-018 Latency SHALL be 1: eop accepted in cycle N gives out_valid=1 in cycle N+1.
REQ-019 While out_valid=1 and out_ready=0, all out_* signals SHALL hold stable.
REQ-020 When PID_COUNT == 1, every packet SHALL be treated as sop&eop, and pid SHALL be ignored.
REQ-021 An accept in GATHER with sop=1 SHALL raise a simulation assertion, and the block SHALL restart the gather. An accept in IDLE with sop=0 SHALL likewise raise a simulation assertion.
REQ-022 Packets with non-increasing pid within one gather SHALL raise a simulation assertion.
REQ-023 busy SHALL be (state != IDLE).

Reset
REQ-024 On reset, state SHALL be IDLE, out_valid=0, busy=0, the gather tmask and data SHALL be 0, and commit_in_if.ready SHALL be 1 in the first cycle after reset deasserts.
REQ-025 Reset asserted mid-gather or in HOLD SHALL discard the partial or held result with no output handshake.
REQ-026 Reset SHALL NOT be required on latched uuid, wid, PC, rd, wb or out_data payload registers beyond REQ-024.

Configuration
REQ-027 Macro DOT8_GATHER_SKID_EN SHALL, when defined, add a second result buffer. In HOLD, commit_in_if.ready stays 1, the next gather proceeds into the free buffer, and ready drops only when both buffers are occupied. out_valid SHALL stay continuously 1 when the next gather completes in the same cycle as the output fires. Results SHALL be delivered in completion order.
REQ-028 Without DOT8_GATHER_SKID_EN, the block SHALL have a single buffer, and commit_in_if.ready=0 throughout HOLD.

Verification
REQ-029 NUM_LANES=1, `NUM_THREADS=4: four packets pid 0..3 with data 1,2,3,4 and eop on pid 3 -> out_data={4,3,2,1}, out_tmask=4'b1111, out_valid in the cycle after the eop accept.
REQ-030 Same configuration, packets pid 0 (sop) and pid 2 (eop) only -> out_tmask=4'b0101, out_data[1]=0, out_data[3]=0.
REQ-031 out_ready held 0 for 5 cycles in HOLD -> outputs stable, commit_in_if.ready=0 (no skid), accept resumes on the cycle after out_ready=1.
REQ-032 Reset asserted after pid 1 of a 4-packet gather -> no out_valid, busy=0; a fresh gather then completes correctly.
REQ-033 With DOT8_GATHER_SKID_EN, two back-to-back sop..eop gathers while out_ready=0 -> both are accepted, and their outputs emerge in order on two consecutive out_ready cycles.
REQ-034 NUM_LANES=`NUM_THREADS, single sop&eop packet with data -5 in every lane -> out_data = 32'hFFFFFFFB in every lane, latency 1.
